// File: rtl/seq_det_pkg.sv
// Shared types and width helpers for the programmable serial pattern detector.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TMO_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register and pattern compare; hit reflects the history as it
// will be after the current shift.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = len_w(DEF_MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               bit_in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               hit
);

  logic [MAX_LEN-1:0] history;
  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   bits_seen;
  logic [LEN_W-1:0]   seen_shift;

  always_comb begin
    hist_shift = {history[MAX_LEN-2:0], bit_in};
    seen_shift = (bits_seen == LEN_W'(MAX_LEN)) ? bits_seen : bits_seen + LEN_W'(1);
    mask       = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = shift_en && (seen_shift >= len) && (((hist_shift ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      history   <= '0;
      bits_seen <= '0;
    end else if (clear) begin
      history   <= '0;
      bits_seen <= '0;
    end else if (shift_en) begin
      // Non-overlapping mode restarts the search after every detection.
      if (hit && !overlap) begin
        history   <= '0;
        bits_seen <= '0;
      end else begin
        history   <= hist_shift;
        bits_seen <= seen_shift;
      end
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller: config handshake, IDLE/RUN/FIN sequencing, match counting,
// target and timeout termination, abort.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TMO_W   = DEF_TMO_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [MAX_LEN-1:0]         cfg_pattern,
  input  logic [len_w(MAX_LEN)-1:0]  cfg_len,
  input  logic                       cfg_overlap,
  input  logic [CNT_W-1:0]           cfg_target,
  input  logic [TMO_W-1:0]           cfg_timeout,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       in_valid,
  input  logic                       in,
  output logic                       match,
  output logic [CNT_W-1:0]           match_cnt,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_flag,
  output logic                       cfg_err
);

  localparam int LEN_W = len_w(MAX_LEN);

  state_t             state;
  state_t             next_state;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;
  logic [CNT_W-1:0]   target;
  logic [TMO_W-1:0]   timeout;
  logic               cfg_loaded;
  logic [TMO_W-1:0]   timer;

  logic len_ok;
  logic target_met;
  logic timed_out;
  logic exit_run;
  logic start_run;
  logic shift_en;
  logic hit;

  assign len_ok     = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));
  // Exit is decided from registered count/timer, so a match and a timeout
  // landing on the same edge both count before the run is judged.
  assign target_met = (target != '0) && (match_cnt == target);
  assign timed_out  = (timeout != '0) && (timer == timeout);
  assign exit_run   = target_met || timed_out;

  assign busy      = (state == RUN);
  assign done      = (state == FIN);
  assign cfg_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_run  = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start && cfg_loaded && !cfg_valid) begin
          next_state = RUN;
          start_run  = 1'b1;
        end
      end
      RUN: begin
        if (exit_run) next_state = FIN;
        else          shift_en   = in_valid;
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort) begin
      next_state = IDLE;
      start_run  = 1'b0;
      shift_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern    <= '0;
      len        <= '0;
      overlap    <= 1'b0;
      target     <= '0;
      timeout    <= '0;
      cfg_loaded <= 1'b0;
      cfg_err    <= 1'b0;
    end else if (state == IDLE && cfg_valid) begin
      if (len_ok) begin
        pattern    <= cfg_pattern;
        len        <= cfg_len;
        overlap    <= cfg_overlap;
        target     <= cfg_target;
        timeout    <= cfg_timeout;
        cfg_loaded <= 1'b1;
        cfg_err    <= 1'b0;
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match        <= 1'b0;
      match_cnt    <= '0;
      timer        <= '0;
      timeout_flag <= 1'b0;
    end else begin
      match <= hit;
      if (start_run) begin
        match_cnt    <= '0;
        timer        <= '0;
        timeout_flag <= 1'b0;
      end else if (state == RUN && !abort) begin
        if (exit_run) begin
          timeout_flag <= !target_met;
        end else begin
          timer <= timer + TMO_W'(1);
          if (hit && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
        end
      end
    end
  end

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_run),
    .shift_en (shift_en),
    .bit_in   (in),
    .pattern  (pattern),
    .len      (len),
    .overlap  (overlap),
    .hit      (hit)
  );

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Run controller for a programmable serial bit-pattern detector, the configurable successor to the team's fixed-pattern Mealy detectors. It accepts a pattern configuration through a valid/ready handshake and arms a detection run on start. During the run it shifts in qualified serial bits and counts matches in overlapping or non-overlapping mode. The run ends on a target match count, a cycle timeout or an abort. It sits between a host/config interface and a serial bit source.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of match counter and target
TMO_W, 16, width of timeout counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous assert, active-low (0 = reset)
cfg_valid  in  1  config offered
cfg_ready  out  1  config accepted when high with cfg_valid
cfg_pattern  in  MAX_LEN  pattern; bit 0 = most recently received bit
cfg_len  in  $clog2(MAX_LEN+1)  pattern length in bits
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
cfg_target  in  CNT_W  matches required to finish; 0 = unlimited
cfg_timeout  in  TMO_W  run limit in clk cycles; 0 = none
start  in  1  begin run (level sampled, IDLE only)
abort  in  1  terminate run
in_valid  in  1  serial bit qualifier
in  in  1  serial data bit
match  out  1  one-cycle pulse per detected pattern
match_cnt  out  CNT_W  matches in current/last run
busy  out  1  high in RUN
done  out  1  one-cycle pulse at normal/timeout completion
timeout_flag  out  1  last run ended by timeout
cfg_err  out  1  last offered config rejected

Behaviour:
- Reset (rst=0): state IDLE; all outputs 0 except cfg_ready=1; config registers cleared; cfg_loaded=0. Effect is immediate, not clock-gated.
- States: IDLE, RUN, FIN.
- IDLE:
  - cfg_ready=1. On cfg_valid, latch config.
  - If cfg_len<2 or cfg_len>MAX_LEN: set cfg_err=1 and leave cfg_loaded unchanged.
  - Otherwise: cfg_err=0, cfg_loaded=1.
  - start with cfg_loaded=1 -> RUN next cycle. On that transition clear history, bits_seen, match_cnt, timer and timeout_flag.
  - start with cfg_loaded=0 is ignored.
  - cfg_valid and start in the same cycle: config is latched first, and start is ignored that cycle.
- RUN:
  - busy=1, cfg_ready=0; cfg_valid is ignored.
  - Each cycle: timer+1.
  - On in_valid: history = {history[MAX_LEN-2:0], in}; bits_seen saturates at MAX_LEN.
  - Match when bits_seen (after update) >= cfg_len and history[cfg_len-1:0] == cfg_pattern[cfg_len-1:0].
  - match is registered: high in the cycle after the edge that sampled the completing bit. match_cnt increments on the same edge and saturates at all-ones.
  - Non-overlap: on a match, history and bits_seen clear to 0.
  - Overlap: history is kept.
  - Exit to FIN when cfg_target!=0 and match_cnt reaches cfg_target.
  - Otherwise exit to FIN when cfg_timeout!=0 and timer reaches cfg_timeout; timeout_flag=1.
  - Match and timeout on the same edge: the match is counted. If it reaches the target, the run is a success and timeout_flag=0.
- abort (highest priority, any state): -> IDLE next edge; busy=0, no done pulse; config retained; match_cnt holds its value.
- FIN: done=1 for exactly one cycle, then IDLE. match_cnt and timeout_flag hold until the next start.
- in_valid outside RUN: ignored.

Decomposition:
- Package seq_det_pkg: state enum (IDLE, RUN, FIN), length-width function/constant, default widths.
- Sub-module seq_match_core:
  - Contains the history shift register, bits_seen, compare and overlap-clear logic.
  - Inputs: clear, shift enable, bit, pattern, len, overlap.
  - Output: combinational hit.
- seq_det_ctrl holds the FSM, config registers, counter, timer and output registers.

Test Plan:
- Config 11011 (pattern=0x1B), len 5, overlap 0, target 2, timeout 0. Serial 1,1,0,1,1,0,1,1,0,1,1 on consecutive cycles -> match after bits 5 and 11; match_cnt=2; done pulse one cycle after the bit-11 match; busy falls.
- Same stream with overlap 1 -> matches after bits 5 and 8; done after bit 8; bits 9-11 ignored; match_cnt stays 2.
- Pattern 111, len 3, target 1, timeout 10; in=0 continuously -> done 10 cycles into RUN with timeout_flag=1 and match_cnt=0. Repeat with a completing 1 landing on cycle 10 -> timeout_flag=0 and match_cnt=1.
- Mid-run abort after 2 matches (target 5) -> IDLE next cycle; no done; match_cnt=2. A later start with no new config reruns and clears match_cnt.
- Drive rst=0 between clock edges during RUN -> busy, match and match_cnt go to 0 immediately; cfg_loaded clears, so start with no new config has no effect.
- Config with cfg_len=1, then cfg_len=9 (MAX_LEN=8) -> cfg_err=1 and start ignored. Valid config next -> cfg_err=0.
